serial_result: RTL
==================

# serial_result

Parallel-to-serial result stage of the gobou fully-connected engine. Captures the CORE per-core results when the layer pipeline finishes an output group, then presents them one per cycle on `write_result`. Cycle-aligned to the image-memory write strobe that `ctrl_core` derives from `serial_we`. Sits between the per-core bias/activation outputs and `ctrl_core`'s `write_result` input.

## Interface
- `CORE`: default from `gobou.svh`; number of parallel cores and result lanes.
- `DWIDTH`: default from `gobou.svh`; signed result width.
- `clk`, input, 1: the single clock.
- `xrst`, input, 1: reset, synchronous and active-low.
- `serial_we`, input, 1: load strobe, the same signal `ctrl_core` drives out.
- `in_result`, input, CORE×DWIDTH, signed: packed lane results; lane 0 is in the LSB slice.
- `write_result`, output, DWIDTH, signed: current serial element.
- `result_valid`, output, 1: `write_result` holds a live element this cycle.
- `busy`, output, 1: shifting is in progress; equals `result_valid`.
- `overrun`, output, 1: sticky flag; a load arrived while elements were still pending.
- `lane_idx`, output, $clog2(CORE+1): index of the lane currently on `write_result`.

## Operation
- State: a shift register `sreg[CORE]` of DWIDTH bits each, and a remaining-count `r_cnt` in 0..CORE.
- Idle: `r_cnt == 0`.
- Load, on a clock edge where `serial_we == 1`:
  - `sreg[i] <= f(in_result[i])` for every lane.
  - `r_cnt <= CORE`.
  - `lane_idx <= 0`.
- Shift, on an edge where `serial_we == 0 && r_cnt > 0`:
  - `sreg[i] <= sreg[i+1]`; `sreg[CORE-1] <= 0`.
  - `r_cnt <= r_cnt - 1`.
  - `lane_idx <= lane_idx + 1`.
- Outputs:
  - `write_result = sreg[0]` while `r_cnt > 0`, otherwise 0.
  - `result_valid = (r_cnt != 0)`; `busy` has the same value.
- `f` is the identity unless the configuration macro is set (see Configuration).
- Load while shifting (`serial_we` while `r_cnt > 1`):
  - The new load wins: shift register reloaded, count reset to CORE.
  - `overrun <= 1`.
  - A load on the edge where `r_cnt == 1` (last element) is legal and does not set `overrun`.
- `overrun` clears only on reset.
- `lane_idx` holds its value while idle.
- Reset mid-shift: all state clears on the next edge; no further elements are emitted.

## Timing
- Reset values:
  - `write_result`, `result_valid`, `busy`, `overrun` = 0.
  - `lane_idx` = 0.
  - `sreg` all 0; `r_cnt` = 0.
- `serial_we` high in cycle T:
  - Lane k appears on `write_result` in cycle T+1+k, for k = 0..CORE-1.
  - `result_valid` is high from T+1 through T+CORE inclusive.
- This matches `ctrl_core`, which registers `mem_img_we` from `serial_we` and holds it for CORE cycles.
- `in_result` is sampled only on the load edge; it need not stay stable afterwards.
- Minimum legal spacing between loads is CORE cycles. Back-to-back groups at exactly CORE spacing give a continuous stream with no bubble.
- No combinational path from inputs to outputs; every output is a register or a mux of registers.

## Configuration
- Macro: `GOBOU_SERIAL_RELU_EN`.
- Defined: `f(x) = (x < 0) ? 0 : x`, applied per lane at load. This is a ReLU folded into the capture, with no extra latency.
- Undefined: `f(x) = x`; results pass unmodified, and activation is assumed to be elsewhere in the pipeline.
- The macro does not change timing, the port list, or the reset behaviour.

## Structure
- Shared package `gobou.svh` holds `CORE`, `DWIDTH`, `LWIDTH`, and the macro default.
- Add to the same package a `typedef logic signed [DWIDTH-1:0] data_t` for lane values.
- No local constants beyond the width of `lane_idx`.
- One sub-module: `serial_lane_act`, the per-lane activation function.
  - Instantiated CORE times in a generate loop.
  - Compiled as a pass-through when the macro is off.

## Test plan
- Reset, then idle 10 cycles -> all outputs stay 0; `result_valid` = 0.
- CORE=4, `in_result` = {40,-3,20,10} (lane3..lane0), `serial_we` pulse at T:
  - Macro off -> `write_result` is 10, 20, -3, 40 at T+1..T+4; `result_valid` high exactly 4 cycles; `lane_idx` 0..3.
- Same stimulus with `GOBOU_SERIAL_RELU_EN` -> sequence 10, 20, 0, 40.
- Two loads exactly CORE cycles apart -> 2·CORE consecutive valid elements, no gap, `overrun` = 0.
- Second load 2 cycles after the first -> stream restarts at the new lane 0 at T+3; `overrun` = 1 and stays 1 until `xrst`.
- `xrst` asserted at T+2 of a shift -> outputs 0 from the next edge; `result_valid` = 0; no residual elements after reset is released.

Source files
------------

// File: rtl/serial_result_pkg.sv
// Shared gobou constants and lane type (stands in for gobou.svh).
// GOBOU_SERIAL_RELU_EN is left undefined by default: results pass through unmodified.
package serial_result_pkg;

   localparam int CORE   = 4;
   localparam int DWIDTH = 16;
   localparam int LWIDTH = $clog2(CORE + 1);

   typedef logic signed [DWIDTH-1:0] data_t;

endpackage

// File: rtl/serial_result_lane_act.sv
// Per-lane activation applied at capture; configured by GOBOU_SERIAL_RELU_EN.
// With the macro undefined this is a plain wire.
module serial_lane_act
   import serial_result_pkg::*;
#(
   parameter int DWIDTH = serial_result_pkg::DWIDTH
) (
   input  logic signed [DWIDTH-1:0] x,
   output logic signed [DWIDTH-1:0] y
);

`ifdef GOBOU_SERIAL_RELU_EN
   // Negative results clamp to zero; sign bit decides, so no compare logic.
   assign y = x[DWIDTH-1] ? '0 : x;
`else
   assign y = x;
`endif

endmodule

// File: rtl/serial_result.sv
// Parallel-to-serial result stage: captures CORE lanes on serial_we and emits
// one lane per cycle on write_result. Optional ReLU via GOBOU_SERIAL_RELU_EN.
module serial_result
   import serial_result_pkg::*;
#(
   parameter int CORE   = serial_result_pkg::CORE,
   parameter int DWIDTH = serial_result_pkg::DWIDTH
) (
   input  logic                       clk,
   input  logic                       xrst,
   input  logic                       serial_we,
   input  logic [CORE*DWIDTH-1:0]     in_result,
   output logic signed [DWIDTH-1:0]   write_result,
   output logic                       result_valid,
   output logic                       busy,
   output logic                       overrun,
   output logic [$clog2(CORE+1)-1:0]  lane_idx
);

   localparam int IW = $clog2(CORE + 1);

   // Stream handshake: result_valid high means write_result carries a live
   // element this cycle; there is no ready, the consumer takes every element.

   logic signed [DWIDTH-1:0] act  [CORE];
   logic signed [DWIDTH-1:0] sreg [CORE];
   logic [IW-1:0]            r_cnt;
   logic [IW-1:0]            lane_q;
   logic                     ovr_q;

   for (genvar i = 0; i < CORE; i++) begin : g_lane
      serial_lane_act #(
         .DWIDTH(DWIDTH)
      ) u_act (
         .x(in_result[i*DWIDTH +: DWIDTH]),
         .y(act[i])
      );
   end

   always_ff @(posedge clk) begin
      if (!xrst) begin
         for (int i = 0; i < CORE; i++) sreg[i] <= '0;
         r_cnt  <= '0;
         lane_q <= '0;
         ovr_q  <= 1'b0;
      end else if (serial_we) begin
         // A reload on the final element is the normal back-to-back case.
         for (int i = 0; i < CORE; i++) sreg[i] <= act[i];
         r_cnt  <= IW'(CORE);
         lane_q <= '0;
         if (r_cnt > IW'(1)) ovr_q <= 1'b1;
      end else if (r_cnt != '0) begin
         for (int i = 0; i < CORE - 1; i++) sreg[i] <= sreg[i+1];
         sreg[CORE-1] <= '0;
         r_cnt  <= r_cnt - IW'(1);
         lane_q <= lane_q + IW'(1);
      end
   end

   assign result_valid = (r_cnt != '0);
   assign busy         = result_valid;
   assign write_result = result_valid ? sreg[0] : '0;
   assign overrun      = ovr_q;
   assign lane_idx     = lane_q;

endmodule
